banked_mem_reader: RTL
======================

// Module: banked_mem_reader
// PURPOSE
// - Read-side companion to the 4-bank, 8-bit, 10-bit-address memory write port.
// - Accepts read requests on a valid/ready handshake and drives the banks' read port (1-cycle latency).
// - Returns data on a valid/ready response channel through a credit-protected 2-entry FIFO.
// - Sits between the formal/bench host and the memory banks; never drops or reorders beats.
// PARAMETERS
// - ADDR_W      10  byte address width; [9:8] selects the bank, [7:0] is the row
// - DATA_W       8  data width per bank
// - BANKS        4  number of banks; must equal 2**(ADDR_W-8)
// - LEN_W        4  burst length field width; a burst is req_len+1 beats (max 16)
// - FIFO_DEPTH   2  response FIFO entries; also the outstanding-read credit limit
// PORTS
// - clk          in   1       single clock, rising edge
// - rst_n        in   1       asynchronous, active-low reset
// - req_valid    in   1       read request valid
// - req_ready    out  1       request accepted when valid&&ready
// - req_addr     in   ADDR_W  start address
// - req_len      in   LEN_W   beats-1 (ignored unless burst is compiled in)
// - mem_ren      out  1       read strobe to the banks
// - mem_bank     out  BANKS   one-hot bank select, 0 when mem_ren=0
// - mem_raddr    out  8       row address within the bank
// - mem_rdata    in   DATA_W  read data from the selected bank, valid the cycle after mem_ren
// - rsp_valid    out  1       response beat valid
// - rsp_ready    in   1       response beat consumed when valid&&ready
// - rsp_data     out  DATA_W  read data
// - rsp_last     out  1       final beat of the request
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE; req_ready=1; mem_ren=0; mem_bank=0; mem_raddr=0;
//   rsp_valid=0; rsp_data=0; rsp_last=0; FIFO empty; in-flight read discarded; credits=FIFO_DEPTH.
// - FSM IDLE: req_ready=1. On accept, latch cur_addr=req_addr and beats_left=req_len, go to ISSUE.
// - FSM ISSUE: req_ready=0. Issue one read per cycle when credits>0:
//   mem_ren=1, mem_bank=1<<cur_addr[9:8], mem_raddr=cur_addr[7:0].
//   Issuing consumes one credit; a pop on rsp consumes no credit; a pop returns one credit.
// - After issuing, cur_addr increments modulo 2**ADDR_W (0x3FF -> 0x000, crosses bank3 -> bank0).
// - On the beat where beats_left==0, tag the in-flight beat last=1 and return to IDLE.
//   req_ready=1 in the following cycle.
// - Data capture: the cycle after mem_ren, push {last, mem_rdata} into the FIFO. A push always
//   succeeds because credits cover FIFO occupancy plus the in-flight read.
// - Response: rsp_valid=!empty; rsp_data/rsp_last show the FIFO head. A push and a pop in the same
//   cycle are both honoured. rsp_data and rsp_last hold stable while rsp_valid && !rsp_ready.
// - Latency: request accepted in cycle N -> mem_ren in N+1 -> rsp_valid in N+3.
//   Throughput: 1 beat/cycle with rsp_ready held high.
// - A request presented while in ISSUE waits and is not lost; req_addr and req_len are sampled only
//   on accept.
// - rsp_ready low with a full FIFO stops issue (credits=0) without losing or duplicating beats.
// - rst_n deasserted mid-burst: everything returns to reset values immediately and there is no
//   partial rsp_last.
// CONFIGURATION
// - MEM_RD_BURST_EN defined: req_len honoured, bursts of 1..16 beats, rsp_last on the final beat.
// - MEM_RD_BURST_EN undefined: req_len ignored (treated as 0), every request is a single beat,
//   rsp_last=1 on every beat, and the beats_left counter is not built.
// STRUCTURE
// - Package mem_rd_pkg: ADDR_W, DATA_W, BANKS, LEN_W; BANK_MSB=9, BANK_LSB=8; the state enum
//   {IDLE, ISSUE}; the function bank_onehot(addr).
// - Sub-module mem_rd_rsp_fifo: DEPTH x (DATA_W+1) synchronous FIFO with push, pop, full and empty,
//   and async active-low reset.
// - The top level holds the FSM, address/length counters, credit counter and 1-cycle capture valid.
// TESTING
// - Single read, bank0 row 0x80 preloaded 0x29: req_addr=0x080 -> mem_bank=0001, mem_raddr=0x80,
//   then rsp_data=0x29, rsp_last=1, rsp_valid 3 cycles after accept.
// - Bank decode, bank2 row 0x80 preloaded 0xFF: req_addr=0x280 -> mem_bank=0100, rsp_data=0xFF.
// - Burst (MEM_RD_BURST_EN): addr=0x0FE, len=3 -> reads 0x0FE, 0x0FF, 0x100, 0x101; bank switches
//   0001 -> 0010; 4 beats with rsp_last only on the 4th beat.
// - Wrap: addr=0x3FF, len=1 -> second read is bank0 row 0x00.
// - Backpressure: rsp_ready=0 for 5 cycles during a 4-beat burst -> at most 2 reads issued,
//   no beat lost, in-order data after release.
// - Reset mid-burst: rst_n low in beat 2 -> rsp_valid=0, mem_ren=0, req_ready=1 immediately;
//   a new request after release completes normally.

Source files
------------

// File: rtl/mem_rd_pkg.sv
// Shared constants, FSM encoding and bank-decode helper for the banked memory reader.
// Optional burst support in the top level is enabled with MEM_RD_BURST_EN.
package mem_rd_pkg;

    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned BANKS      = 4;
    localparam int unsigned LEN_W      = 4;
    localparam int unsigned FIFO_DEPTH = 2;

    localparam int unsigned BANK_MSB   = 9;
    localparam int unsigned BANK_LSB   = 8;
    localparam int unsigned ROW_W      = BANK_LSB;

    localparam int unsigned CRED_W     = $clog2(FIFO_DEPTH + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    function automatic logic [BANKS-1:0] bank_onehot(input logic [ADDR_W-1:0] addr);
        logic [BANKS-1:0] one;
        one = {{(BANKS-1){1'b0}}, 1'b1};
        return one << (addr >> BANK_LSB);
    endfunction

endpackage

// File: rtl/mem_rd_rsp_fifo.sv
// Small synchronous FIFO holding {last, data} response beats; async active-low reset.
// Head output reads as zero while empty so the response bus is quiet when idle.
module mem_rd_rsp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= (rptr == PTR_W'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wptr] <= wdata;
        end
    end

    assign rdata = empty ? '0 : store[rptr];

endmodule

// File: rtl/banked_mem_reader.sv
// Read front-end for the 4-bank memory: request FSM, credit-limited issue, 1-cycle capture
// and response FIFO. Define MEM_RD_BURST_EN to honour req_len as a burst length.
module banked_mem_reader
    import mem_rd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              mem_ren,
    output logic [BANKS-1:0]  mem_bank,
    output logic [ROW_W-1:0]  mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last
);

    logic [0:0]        state;
    logic [0:0]        state_d;
    logic [ADDR_W-1:0] cur_addr;
    logic [CRED_W-1:0] credits;
    logic              cap_valid;
    logic              cap_last;

    logic              accept;
    logic              issue;
    logic              pop;
    logic              final_beat;
    logic              fifo_empty;
    logic              fifo_full_unused;
    logic [DATA_W:0]   fifo_rdata;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;

    // A pop this cycle frees a slot before the next capture, so it can fund an issue directly;
    // this keeps one beat per cycle with only two credits.
    assign issue = (state == ISSUE) && ((credits != '0) || pop);

`ifdef MEM_RD_BURST_EN
    logic [LEN_W-1:0] beats_left;

    assign final_beat = (beats_left == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_left <= '0;
        end else if (accept) begin
            beats_left <= req_len;
        end else if (issue) begin
            beats_left <= beats_left - 1'b1;
        end
    end
`else
    logic len_unused;

    assign len_unused = ^req_len;
    assign final_beat = 1'b1;
`endif

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue && final_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            credits   <= CRED_W'(FIFO_DEPTH);
            cap_valid <= 1'b0;
            cap_last  <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                cur_addr <= req_addr;
            end else if (issue) begin
                cur_addr <= cur_addr + 1'b1;
            end
            credits   <= credits - CRED_W'(issue) + CRED_W'(pop);
            cap_valid <= issue;
            cap_last  <= issue && final_beat;
        end
    end

    assign mem_ren   = issue;
    assign mem_bank  = issue ? bank_onehot(cur_addr) : '0;
    assign mem_raddr = issue ? cur_addr[ROW_W-1:0] : '0;

    mem_rd_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cap_valid),
        .wdata ({cap_last, mem_rdata}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full_unused),
        .empty (fifo_empty)
    );

    assign rsp_data = fifo_rdata[DATA_W-1:0];
    assign rsp_last = fifo_rdata[DATA_W];

endmodule
